// File: rtl/pong_game_ctrl_if.sv
// Signal bundle between the pong game controller and its surroundings
// (VGA frame tick, start button, ball/paddle datapath).
interface pong_game_ctrl_if;
  logic       frame_tick;
  logic       btn_start;
  logic       miss_left;
  logic       miss_right;
  logic       update_en;
  logic       ball_reset;
  logic       serve_dir;
  logic [3:0] score_left;
  logic [3:0] score_right;
  logic       game_over;
  logic [2:0] state;

  // Controller side: consumes events, drives strobes, scores and state.
  modport master (
    input  frame_tick, btn_start, miss_left, miss_right,
    output update_en, ball_reset, serve_dir, score_left, score_right,
           game_over, state
  );

  // Surrounding side: produces events, observes the controller.
  modport slave (
    output frame_tick, btn_start, miss_left, miss_right,
    input  update_en, ball_reset, serve_dir, score_left, score_right,
           game_over, state
  );
endinterface

// File: rtl/pong_game_ctrl.sv
// Pong frame-level sequencer: game FSM, frame-paced update strobes,
// ball re-centre pulses and score keeping.
module pong_game_ctrl #(
  parameter int WIN_SCORE          = 7,
  parameter int SERVE_DELAY_FRAMES = 60,
  parameter int POINT_DELAY_FRAMES = 90,
  parameter int SPEED_DIV          = 1
) (
  input  logic             clk,
  input  logic             rst,
  pong_game_ctrl_if.master bus
);

  localparam logic [3:0] WIN_C   = 4'(WIN_SCORE);
  localparam logic [7:0] SERVE_C = 8'(SERVE_DELAY_FRAMES);
  localparam logic [7:0] POINT_C = 8'(POINT_DELAY_FRAMES);
  localparam logic [3:0] DIV_C   = 4'(SPEED_DIV);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_SERVE = 3'd1,
    S_PLAY  = 3'd2,
    S_POINT = 3'd3,
    S_OVER  = 3'd4
  } state_t;

  state_t     state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic [3:0] div_q, div_d;
  logic       btn_q, btn_d;
  logic [3:0] score_l_q, score_l_d;
  logic [3:0] score_r_q, score_r_d;
  logic       serve_dir_q, serve_dir_d;
  logic       update_en_q, update_en_d;
  logic       ball_reset_q, ball_reset_d;

  logic       start_edge;
  logic [7:0] cnt_inc;
  logic [3:0] div_inc;
  logic [3:0] score_l_inc;
  logic [3:0] score_r_inc;

  // Next-state, counters, scores and registered strobes.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    div_d        = div_q;
    btn_d        = bus.btn_start;
    score_l_d    = score_l_q;
    score_r_d    = score_r_q;
    serve_dir_d  = serve_dir_q;
    update_en_d  = 1'b0;
    ball_reset_d = 1'b0;

    start_edge  = bus.btn_start & ~btn_q;
    cnt_inc     = cnt_q + 8'd1;
    div_inc     = div_q + 4'd1;
    score_l_inc = (score_l_q < WIN_C) ? score_l_q + 4'd1 : score_l_q;
    score_r_inc = (score_r_q < WIN_C) ? score_r_q + 4'd1 : score_r_q;

    case (state_q)
      S_IDLE, S_OVER: begin
        if (start_edge) begin
          score_l_d    = 4'd0;
          score_r_d    = 4'd0;
          serve_dir_d  = 1'b0;
          state_d      = S_SERVE;
          ball_reset_d = 1'b1;
        end
      end
      S_SERVE: begin
        if (bus.frame_tick && cnt_inc == SERVE_C) state_d = S_PLAY;
      end
      S_PLAY: begin
        if (bus.miss_left && bus.miss_right) begin
          // Double miss: replay the point without scoring.
          state_d = S_POINT;
        end else if (bus.miss_left) begin
          score_r_d   = score_r_inc;
          serve_dir_d = 1'b1;
          state_d     = (score_r_inc == WIN_C) ? S_OVER : S_POINT;
        end else if (bus.miss_right) begin
          score_l_d   = score_l_inc;
          serve_dir_d = 1'b0;
          state_d     = (score_l_inc == WIN_C) ? S_OVER : S_POINT;
        end else if (bus.frame_tick) begin
          if (div_inc == DIV_C) begin
            div_d       = 4'd0;
            update_en_d = 1'b1;
          end else begin
            div_d = div_inc;
          end
        end
      end
      S_POINT: begin
        if (bus.frame_tick && cnt_inc == POINT_C) begin
          state_d      = S_SERVE;
          ball_reset_d = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Frame counter restarts on every state change; the tick that
    // causes the change is not carried into the new state.
    if (state_d != state_q)   cnt_d = 8'd0;
    else if (bus.frame_tick)  cnt_d = cnt_inc;

    if (state_d == S_PLAY && state_q != S_PLAY) div_d = 4'd0;
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      cnt_q        <= 8'd0;
      div_q        <= 4'd0;
      btn_q        <= 1'b0;
      score_l_q    <= 4'd0;
      score_r_q    <= 4'd0;
      serve_dir_q  <= 1'b0;
      update_en_q  <= 1'b0;
      ball_reset_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      div_q        <= div_d;
      btn_q        <= btn_d;
      score_l_q    <= score_l_d;
      score_r_q    <= score_r_d;
      serve_dir_q  <= serve_dir_d;
      update_en_q  <= update_en_d;
      ball_reset_q <= ball_reset_d;
    end
  end

  assign bus.update_en   = update_en_q;
  assign bus.ball_reset  = ball_reset_q;
  assign bus.serve_dir   = serve_dir_q;
  assign bus.score_left  = score_l_q;
  assign bus.score_right = score_r_q;
  assign bus.game_over   = (state_q == S_OVER);
  assign bus.state       = state_q;

endmodule

// File: tb/tb_pong_game_ctrl.sv
// Directed bench for pong_game_ctrl. Two instances share stimulus:
// A uses SPEED_DIV=1, B uses SPEED_DIV=3; otherwise WIN=3, delays=2.
module tb_pong_game_ctrl;
  logic clk, rst;
  logic frame_tick, btn_start, miss_left, miss_right;
  int   tests, fails;
  int   upd_cnt_a, upd_cnt_b, br_cnt_a;
  logic both_a, both_b;
  int   base_a, base_b, base_br;

  pong_game_ctrl_if bif_a ();
  pong_game_ctrl_if bif_b ();

  assign bif_a.frame_tick = frame_tick;
  assign bif_a.btn_start  = btn_start;
  assign bif_a.miss_left  = miss_left;
  assign bif_a.miss_right = miss_right;
  assign bif_b.frame_tick = frame_tick;
  assign bif_b.btn_start  = btn_start;
  assign bif_b.miss_left  = miss_left;
  assign bif_b.miss_right = miss_right;

  pong_game_ctrl #(.WIN_SCORE(3), .SERVE_DELAY_FRAMES(2),
                   .POINT_DELAY_FRAMES(2), .SPEED_DIV(1))
    dut_a (.clk(clk), .rst(rst), .bus(bif_a));

  pong_game_ctrl #(.WIN_SCORE(3), .SERVE_DELAY_FRAMES(2),
                   .POINT_DELAY_FRAMES(2), .SPEED_DIV(3))
    dut_b (.clk(clk), .rst(rst), .bus(bif_b));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    upd_cnt_a = 0; upd_cnt_b = 0; br_cnt_a = 0;
    both_a = 1'b0; both_b = 1'b0;
  end

  // Pulse counters and overlap monitor, sampled away from the active edge.
  always @(negedge clk) begin
    if (bif_a.update_en === 1'b1) upd_cnt_a++;
    if (bif_b.update_en === 1'b1) upd_cnt_b++;
    if (bif_a.ball_reset === 1'b1) br_cnt_a++;
    if (bif_a.update_en === 1'b1 && bif_a.ball_reset === 1'b1) both_a = 1'b1;
    if (bif_b.update_en === 1'b1 && bif_b.ball_reset === 1'b1) both_b = 1'b1;
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic tick();
    frame_tick = 1'b1;
    cyc();
    frame_tick = 1'b0;
  endtask

  task automatic pulse_miss(input logic l, input logic r);
    miss_left  = l;
    miss_right = r;
    cyc();
    miss_left  = 1'b0;
    miss_right = 1'b0;
  endtask

  // SERVE -> PLAY with SERVE_DELAY_FRAMES=2.
  task automatic go_play();
    tick(); cyc(); tick(); cyc();
  endtask

  // POINT -> SERVE -> PLAY.
  task automatic point_to_play();
    tick(); cyc(); tick(); cyc();
    go_play();
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    tests = 0; fails = 0;
    rst = 1'b1; frame_tick = 1'b0; btn_start = 1'b0;
    miss_left = 1'b0; miss_right = 1'b0;

    // Reset then idle.
    cyc(); cyc();
    rst = 1'b0;
    chk("rst_state",  16'(bif_a.state), 16'd0);
    chk("rst_sl",     16'(bif_a.score_left), 16'd0);
    chk("rst_sr",     16'(bif_a.score_right), 16'd0);
    chk("rst_upd",    16'(bif_a.update_en), 16'd0);
    chk("rst_br",     16'(bif_a.ball_reset), 16'd0);
    chk("rst_go",     16'(bif_a.game_over), 16'd0);
    chk("rst_dir",    16'(bif_a.serve_dir), 16'd0);
    base_a = upd_cnt_a;
    for (int i = 0; i < 5; i++) begin tick(); cyc(); end
    chk("idle_state", 16'(bif_a.state), 16'd0);
    chk("idle_upd_cnt", 16'(upd_cnt_a - base_a), 16'd0);

    // Start, button held: one ball_reset only.
    base_br = br_cnt_a;
    btn_start = 1'b1;
    cyc();
    chk("start_br",    16'(bif_a.ball_reset), 16'd1);
    repeat (99) cyc();
    chk("start_br_cnt", 16'(br_cnt_a - base_br), 16'd1);
    chk("start_state", 16'(bif_a.state), 16'd1);
    btn_start = 1'b0;
    cyc();

    tick();
    chk("serve_t1_state", 16'(bif_a.state), 16'd1);
    cyc();
    tick();
    chk("serve_t2_state", 16'(bif_a.state), 16'd2);
    cyc();

    for (int i = 0; i < 3; i++) begin
      tick();
      chk("play_upd_hi", 16'(bif_a.update_en), 16'd1);
      chk("play_br_lo",  16'(bif_a.ball_reset), 16'd0);
      cyc();
      chk("play_upd_lo", 16'(bif_a.update_en), 16'd0);
    end

    // Divider: instance B pulses after ticks 3, 6, 9.
    base_a = upd_cnt_a; base_b = upd_cnt_b;
    for (int i = 0; i < 9; i++) begin
      tick();
      chk("div_b_upd", 16'(bif_b.update_en), (i % 3 == 2) ? 16'd1 : 16'd0);
      cyc();
    end
    chk("div_b_cnt", 16'(upd_cnt_b - base_b), 16'd3);
    chk("div_a_cnt", 16'(upd_cnt_a - base_a), 16'd9);

    // miss_right with a coincident tick: score, no update strobe.
    miss_right = 1'b1; frame_tick = 1'b1;
    cyc();
    miss_right = 1'b0; frame_tick = 1'b0;
    chk("mr_state", 16'(bif_a.state), 16'd3);
    chk("mr_sl",    16'(bif_a.score_left), 16'd1);
    chk("mr_sr",    16'(bif_a.score_right), 16'd0);
    chk("mr_dir",   16'(bif_a.serve_dir), 16'd0);
    chk("mr_upd_a", 16'(bif_a.update_en), 16'd0);
    chk("mr_upd_b", 16'(bif_b.update_en), 16'd0);

    pulse_miss(1'b1, 1'b0);
    chk("point_miss_ign", 16'(bif_a.score_right), 16'd0);
    btn_start = 1'b1; cyc(); btn_start = 1'b0;
    chk("point_start_ign", 16'(bif_a.state), 16'd3);

    tick();
    chk("point_t1_state", 16'(bif_a.state), 16'd3);
    cyc();
    tick();
    chk("point_t2_state", 16'(bif_a.state), 16'd1);
    chk("point_t2_br",    16'(bif_a.ball_reset), 16'd1);
    cyc();
    chk("point_br_lo",    16'(bif_a.ball_reset), 16'd0);

    go_play();
    chk("replay_state", 16'(bif_a.state), 16'd2);
    pulse_miss(1'b1, 1'b0);
    chk("ml_sr",    16'(bif_a.score_right), 16'd1);
    chk("ml_dir",   16'(bif_a.serve_dir), 16'd1);
    chk("ml_state", 16'(bif_a.state), 16'd3);

    point_to_play();
    pulse_miss(1'b1, 1'b1);
    chk("both_sl",    16'(bif_a.score_left), 16'd1);
    chk("both_sr",    16'(bif_a.score_right), 16'd1);
    chk("both_dir",   16'(bif_a.serve_dir), 16'd1);
    chk("both_state", 16'(bif_a.state), 16'd3);

    // Game end at WIN_SCORE=3.
    rst = 1'b1; cyc(); rst = 1'b0;
    btn_start = 1'b1; cyc(); btn_start = 1'b0;
    go_play();
    pulse_miss(1'b1, 1'b0);
    chk("g1_state", 16'(bif_a.state), 16'd3);
    point_to_play();
    pulse_miss(1'b1, 1'b0);
    chk("g2_sr", 16'(bif_a.score_right), 16'd2);
    point_to_play();
    pulse_miss(1'b1, 1'b0);
    chk("over_sr",    16'(bif_a.score_right), 16'd3);
    chk("over_state", 16'(bif_a.state), 16'd4);
    chk("over_go",    16'(bif_a.game_over), 16'd1);
    pulse_miss(1'b1, 1'b0);
    pulse_miss(1'b0, 1'b1);
    tick(); cyc(); tick(); cyc();
    chk("over_frz_sl", 16'(bif_a.score_left), 16'd0);
    chk("over_frz_sr", 16'(bif_a.score_right), 16'd3);
    chk("over_hold",   16'(bif_a.state), 16'd4);
    btn_start = 1'b1; cyc(); btn_start = 1'b0;
    chk("restart_state", 16'(bif_a.state), 16'd1);
    chk("restart_sl",    16'(bif_a.score_left), 16'd0);
    chk("restart_sr",    16'(bif_a.score_right), 16'd0);
    chk("restart_dir",   16'(bif_a.serve_dir), 16'd0);
    chk("restart_br",    16'(bif_a.ball_reset), 16'd1);
    chk("restart_go",    16'(bif_a.game_over), 16'd0);

    // Build 2/1 then reset mid-PLAY.
    go_play();
    pulse_miss(1'b0, 1'b1);
    point_to_play();
    pulse_miss(1'b0, 1'b1);
    point_to_play();
    pulse_miss(1'b1, 1'b0);
    point_to_play();
    chk("pre_rst_state", 16'(bif_a.state), 16'd2);
    chk("pre_rst_sl",    16'(bif_a.score_left), 16'd2);
    chk("pre_rst_sr",    16'(bif_a.score_right), 16'd1);
    rst = 1'b1; frame_tick = 1'b1;
    cyc();
    rst = 1'b0; frame_tick = 1'b0;
    chk("mrst_state", 16'(bif_a.state), 16'd0);
    chk("mrst_sl",    16'(bif_a.score_left), 16'd0);
    chk("mrst_sr",    16'(bif_a.score_right), 16'd0);
    chk("mrst_dir",   16'(bif_a.serve_dir), 16'd0);
    chk("mrst_upd",   16'(bif_a.update_en), 16'd0);
    chk("mrst_br",    16'(bif_a.ball_reset), 16'd0);
    chk("mrst_go",    16'(bif_a.game_over), 16'd0);
    base_a = upd_cnt_a;
    pulse_miss(1'b1, 1'b0);
    pulse_miss(1'b0, 1'b1);
    tick(); cyc();
    chk("post_rst_sl",    16'(bif_a.score_left), 16'd0);
    chk("post_rst_sr",    16'(bif_a.score_right), 16'd0);
    chk("post_rst_state", 16'(bif_a.state), 16'd0);
    chk("post_rst_upd",   16'(upd_cnt_a - base_a), 16'd0);

    chk("overlap_a", 16'(both_a), 16'd0);
    chk("overlap_b", 16'(both_b), 16'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/pong_game_ctrl.md
Name: pong_game_ctrl

Overview:
- Frame-level sequencer for the pong datapath.
- Runs the game state machine: idle, serve, play, point, game over.
- Gates ball/paddle updates to one strobe per N video frames and issues ball re-centre pulses.
- Keeps both scores. Sits between the VGA timing generator (frame tick) and the pong ball/paddle logic.

Parameters:
- WIN_SCORE, 7, score that ends the game (1..15)
- SERVE_DELAY_FRAMES, 60, frames the ball is held centred before play starts (1..255)
- POINT_DELAY_FRAMES, 90, frames of pause after a point before the next serve (1..255)
- SPEED_DIV, 1, frames per update_en strobe during play (1..15)

Ports:
- clk  in  1  system/pixel clock
- rst  in  1  synchronous, active-high reset
- frame_tick  in  1  one-cycle pulse at start of vertical blanking
- btn_start  in  1  start/restart button, already synchronised, level
- miss_left  in  1  one-cycle pulse: ball passed left paddle
- miss_right  in  1  one-cycle pulse: ball passed right paddle
- update_en  out  1  one-cycle strobe: datapath advances ball/paddles one step
- ball_reset  out  1  one-cycle strobe: datapath re-centres ball
- serve_dir  out  1  0 = serve rightward, 1 = serve leftward
- score_left  out  4  left player score
- score_right  out  4  right player score
- game_over  out  1  high while in OVER
- state  out  3  IDLE=0, SERVE=1, PLAY=2, POINT=3, OVER=4

Behaviour:
- One clock; reset is synchronous and active-high.
- Reset values:
  - state=IDLE; all scores 0; serve_dir=0.
  - update_en, ball_reset, game_over all 0.
  - Frame counter, divider and start-edge register cleared.
- btn_start is edge-detected internally; only a 0->1 transition counts. Holding the button never retriggers.
- Frame counter: 8-bit. Cleared on every state entry. Increments on frame_tick. A tick in the same cycle as a state entry is not counted.
- IDLE:
  - On start edge: scores <= 0, serve_dir <= 0, go to SERVE, assert ball_reset the next cycle.
- SERVE:
  - When the counter reaches SERVE_DELAY_FRAMES on a tick, go to PLAY.
  - Divider is cleared on entry to PLAY.
- PLAY:
  - Each frame_tick increments the divider. When the divider reaches SPEED_DIV, it wraps to 0 and update_en pulses.
  - update_en is registered: high exactly one cycle, the cycle after the qualifying frame_tick.
  - miss_left alone: score_right+1, serve_dir <= 1 (toward the conceding player).
  - miss_right alone: score_left+1, serve_dir <= 0.
  - miss_left and miss_right in the same cycle: no score change, serve_dir unchanged, go to POINT.
  - After a score: if the new score == WIN_SCORE go to OVER, else go to POINT.
  - No update_en is issued in the cycle after a miss.
- POINT:
  - When the counter reaches POINT_DELAY_FRAMES, go to SERVE and pulse ball_reset one cycle later.
- OVER:
  - game_over=1; scores frozen.
  - On start edge: scores <= 0, serve_dir <= 0, go to SERVE, pulse ball_reset.
- Outside PLAY: miss pulses are ignored and update_en stays 0.
- Start edge outside IDLE/OVER is ignored (no mid-game restart).
- Scores never exceed WIN_SCORE; no wrap.
- rst asserted mid-game: next cycle matches reset values exactly. No ball_reset pulse is emitted by reset itself.
- ball_reset and update_en are never high in the same cycle.

Test Plan:
- Reset then idle: rst=1 for 2 cycles, 5 frame_ticks, no btn_start -> state=0, update_en never 1, scores 0/0.
- Start/serve (SERVE_DELAY_FRAMES=2, SPEED_DIV=1):
  - btn_start 0->1, held 100 cycles -> single ball_reset pulse, state=1.
  - After 2nd tick, state=2.
  - Each subsequent tick gives update_en exactly one cycle later.
- Divider: SPEED_DIV=3 in PLAY, 9 frame_ticks -> exactly 3 update_en pulses, following ticks 3, 6 and 9.
- Scoring (POINT_DELAY_FRAMES=2):
  - miss_right pulse -> score_left=1, serve_dir=0, state=3.
  - After 2 ticks -> ball_reset pulse, state=1.
  - Simultaneous miss_left+miss_right -> scores unchanged, state=3.
- Game end (WIN_SCORE=3): three miss_left in play -> score_right=3, state=4, game_over=1. Further misses leave scores at 0/3. Start edge -> scores 0/0, state=1.
- Reset mid-PLAY with score 2/1 -> next cycle state=0, scores 0/0, outputs 0; misses ignored until a new start edge.
